// File: rtl/cpu_host_seq.sv
// Host sequencer: loads a program image into the CPU, starts it, then dumps regs and a DM window.
// One byte/cycle load via s_valid/s_ready; dump bytes held on m_valid until m_ready. Watchdog via CPU_WDOG_EN.
module cpu_host_seq #(
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int RD_LAT   = 1,
  parameter int WDOG_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_go,
  input  logic [ADDR_W-1:0] i_dm_st,
  input  logic [ADDR_W-1:0] i_dm_ed,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              cpu_is_reg,
  output logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_inst,
  output logic              cpu_start,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_done,
  output logic              o_busy,
  output logic              o_err,
  output logic [15:0]       o_cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_PAD    = 3'd2;
  localparam logic [2:0] S_ARM    = 3'd3;
  localparam logic [2:0] S_START  = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_RD_REG = 3'd6;
  localparam logic [2:0] S_RD_DM  = 3'd7;

  localparam int                LAT_W    = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_MAX  = '1;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] dm_st;
  logic [ADDR_W-1:0] dm_ed;
  logic [LAT_W-1:0]  lat_cnt;
  logic              dm_any;
  logic              rd_last;

  assign s_ready = (state == S_LOAD);
  assign o_busy  = (state != S_IDLE);
  assign dm_any  = (dm_st < dm_ed);
  assign rd_last = (state == S_RD_REG) ? (cpu_addr == LAST_REG && !dm_any)
                                       : (cpu_addr == dm_ed - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      dm_st      <= '0;
      dm_ed      <= '0;
      lat_cnt    <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      cpu_is_reg <= 1'b0;
      cpu_addr   <= '0;
      cpu_inst   <= '0;
      cpu_start  <= 1'b0;
      o_err      <= 1'b0;
      o_cycles   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cpu_addr   <= '0;
          cpu_inst   <= '0;
          cpu_is_reg <= 1'b0;
          if (i_go) begin
            dm_st    <= i_dm_st;
            dm_ed    <= i_dm_ed;
            o_err    <= 1'b0;
            o_cycles <= '0;
            ptr      <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (s_valid) begin
            cpu_addr <= ptr;
            cpu_inst <= s_data;
            ptr      <= ptr + ONE;
            // An even final address leaves half an instruction; PAD completes it.
            if (s_last)                state <= ptr[0] ? S_ARM : S_PAD;
            else if (ptr == PTR_MAX) begin
              o_err <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_PAD: begin
          cpu_addr <= ptr;
          cpu_inst <= '0;
          state    <= S_ARM;
        end
        S_ARM: begin
          cpu_addr  <= '0;
          cpu_inst  <= '0;
          cpu_start <= 1'b1;
          state     <= S_START;
        end
        S_START: begin
          cpu_start <= 1'b0;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (o_cycles != 16'hFFFF) o_cycles <= o_cycles + 16'd1;
          if (cpu_done) begin
            state      <= S_RD_REG;
            cpu_is_reg <= 1'b1;
            cpu_addr   <= '0;
            lat_cnt    <= '0;
          end
`ifdef CPU_WDOG_EN
          else if (o_cycles == 16'(WDOG_CYC - 1)) begin
            o_err <= 1'b1;
            state <= S_IDLE;
          end
`endif
        end
        default: begin
          // Read phases: wait RD_LAT after the address settles, then offer the byte.
          if (!m_valid) begin
            if (lat_cnt == LAT_W'(RD_LAT)) begin
              m_valid <= 1'b1;
              m_data  <= cpu_data;
              m_last  <= rd_last;
            end else begin
              lat_cnt <= lat_cnt + LAT_W'(1);
            end
          end else if (m_ready) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            lat_cnt <= '0;
            if (m_last) begin
              state      <= S_IDLE;
              cpu_is_reg <= 1'b0;
              cpu_addr   <= '0;
            end else if (state == S_RD_REG && cpu_addr == LAST_REG) begin
              state      <= S_RD_DM;
              cpu_is_reg <= 1'b0;
              cpu_addr   <= dm_st;
            end else begin
              cpu_addr <= cpu_addr + ONE;
            end
          end
        end
      endcase
    end
  end

endmodule
